// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC sequencer: FSM encoding,
// binary-angle constants and the arctangent table in binary-angle units.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Binary angles on a 32-bit scale (+/-pi == +/-2^31); narrower widths shift down.
  localparam logic [31:0] ANG_PI      = 32'h8000_0000;
  localparam logic [31:0] ANG_HALF_PI = 32'h4000_0000;

  // round(atan(2^-idx) * 2^(dw-1) / pi) for dw up to 32.
  function automatic logic [31:0] atan_ang(input int idx, input int dw);
    logic [63:0] v;
    case (idx)
      0:  v = 64'd536870912;
      1:  v = 64'd316933406;
      2:  v = 64'd167458908;
      3:  v = 64'd85004756;
      4:  v = 64'd42667335;
      5:  v = 64'd21354465;
      6:  v = 64'd10679838;
      7:  v = 64'd5340245;
      8:  v = 64'd2670163;
      9:  v = 64'd1335087;
      10: v = 64'd667544;
      11: v = 64'd333772;
      12: v = 64'd166886;
      13: v = 64'd83443;
      14: v = 64'd41722;
      15: v = 64'd20861;
      default: v = 64'd683565276 >> idx;
    endcase
    if (dw < 32) begin
      v = (v + (64'd1 << (31 - dw))) >> (32 - dw);
    end
    return v[31:0];
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index -> atan(2^-i) as a DW-bit binary angle.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int DW = 16,
  parameter int SW = 3
) (
  input  logic [SW-1:0] i_idx,
  output logic [DW-1:0] o_angle
);

  logic [31:0] w_full;

  always_comb begin
    w_full  = atan_ang(int'(i_idx), DW);
    o_angle = w_full[DW-1:0];
  end

endmodule

// File: rtl/cordic_seq.sv
// Sequencer for a single-stage iterative CORDIC core: load, ITER steps, result handshake.
// Optional CORDIC_QUAD_PRE_EN adds quadrant pre-rotation for full +/-pi rotation range.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int DW   = 16,
  parameter int SW   = 3,
  parameter int ITER = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] y_i,
  input  logic signed [DW-1:0] z_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x_o,
  output logic signed [DW-1:0] y_o,
  output logic signed [DW-1:0] z_o,
  output logic                 core_enable,
  output logic                 core_mode,
  output logic signed [DW-1:0] core_x,
  output logic signed [DW-1:0] core_y,
  output logic signed [DW-1:0] core_z,
  output logic [SW-1:0]        core_shift,
  output logic [DW-1:0]        core_angle,
  input  logic signed [DW-1:0] core_xr,
  input  logic signed [DW-1:0] core_yr,
  input  logic signed [DW-1:0] core_zr
);

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_mode;
  logic [SW-1:0]        r_cnt;
  logic signed [DW-1:0] r_x, r_y, r_z;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_last;
  logic signed [DW-1:0] w_px, w_py, w_pz;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = r_in_ready & in_valid;
  assign w_last   = (r_cnt == SW'(ITER - 1));

`ifdef CORDIC_QUAD_PRE_EN
  localparam logic signed [DW-1:0] L_HALF_PI = DW'(ANG_HALF_PI >> (32 - DW));

  // Fold |z| > pi/2 into range with an exact +/-90 degree swap before loading.
  always_comb begin
    w_px = x_i;
    w_py = y_i;
    w_pz = z_i;
    if (!mode_i && (z_i > L_HALF_PI)) begin
      w_px = -y_i;
      w_py = x_i;
      w_pz = z_i - L_HALF_PI;
    end else if (!mode_i && (z_i < -L_HALF_PI)) begin
      w_px = y_i;
      w_py = -x_i;
      w_pz = z_i + L_HALF_PI;
    end
  end
`else
  assign w_px = x_i;
  assign w_py = y_i;
  assign w_pz = z_i;
`endif

  assign core_enable = w_idle & in_valid;
  assign core_mode   = w_idle ? mode_i : r_mode;
  assign core_x      = w_px;
  assign core_y      = w_py;
  assign core_z      = w_pz;
  assign core_shift  = r_cnt;

  cordic_atan_rom #(
    .DW (DW),
    .SW (SW)
  ) u_atan_rom (
    .i_idx   (r_cnt),
    .o_angle (core_angle)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign x_o       = r_x;
  assign y_o       = r_y;
  assign z_o       = r_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode     <= mode_i;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          // Core outputs on the last step already hold the final iteration.
          if (w_last) begin
            r_x         <= core_xr;
            r_y         <= core_yr;
            r_z         <= core_zr;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_seq.sv
// Bench for cordic_seq: behavioural iterative core plus a whole-operation CORDIC reference.
module tb_cordic_seq;

  localparam int DW   = 16;
  localparam int SW   = 3;
  localparam int ITER = 8;
  localparam real PI  = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode_i;
  logic signed [DW-1:0] x_i, y_i, z_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x_o, y_o, z_o;
  logic                 core_enable;
  logic                 core_mode;
  logic signed [DW-1:0] core_x, core_y, core_z;
  logic [SW-1:0]        core_shift;
  logic [DW-1:0]        core_angle;
  logic signed [DW-1:0] core_xr, core_yr, core_zr;

  always #5 clk = ~clk;

  cordic_seq #(
    .DW   (DW),
    .SW   (SW),
    .ITER (ITER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode_i      (mode_i),
    .x_i         (x_i),
    .y_i         (y_i),
    .z_i         (z_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .x_o         (x_o),
    .y_o         (y_o),
    .z_o         (z_o),
    .core_enable (core_enable),
    .core_mode   (core_mode),
    .core_x      (core_x),
    .core_y      (core_y),
    .core_z      (core_z),
    .core_shift  (core_shift),
    .core_angle  (core_angle),
    .core_xr     (core_xr),
    .core_yr     (core_yr),
    .core_zr     (core_zr)
  );

  // Responder core: loads on enable, otherwise performs one micro-rotation per clock.
  logic signed [DW-1:0] c_x, c_y, c_z, c_sx, c_sy;
  logic                 c_dpos;

  always_comb begin
    c_dpos = core_mode ? (c_y < 0) : (c_z >= 0);
    c_sx   = c_x >>> core_shift;
    c_sy   = c_y >>> core_shift;
    if (c_dpos) begin
      core_xr = c_x - c_sy;
      core_yr = c_y + c_sx;
      core_zr = c_z - $signed(core_angle);
    end else begin
      core_xr = c_x + c_sy;
      core_yr = c_y - c_sx;
      core_zr = c_z + $signed(core_angle);
    end
  end

  always @(posedge clk) begin
    if (core_enable) begin
      c_x <= core_x;
      c_y <= core_y;
      c_z <= core_z;
    end else begin
      c_x <= core_xr;
      c_y <= core_yr;
      c_z <= core_zr;
    end
  end

  int      n_checks = 0;
  int      n_pass   = 0;
  int      n_fail   = 0;
  int      ang_tab[ITER];
  shortint exp_x, exp_y, exp_z;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pre_rot(input logic m, input shortint x, input shortint y, input shortint z,
                         output shortint px, output shortint py, output shortint pz);
    px = x; py = y; pz = z;
`ifdef CORDIC_QUAD_PRE_EN
    if (!m && z > 16384) begin
      px = shortint'(-int'(y)); py = x; pz = shortint'(int'(z) - 16384);
    end else if (!m && z < -16384) begin
      px = y; py = shortint'(-int'(x)); pz = shortint'(int'(z) + 16384);
    end
`endif
  endtask

  // Whole-operation reference: ITER shift-and-add micro-rotations in 16-bit wrapping arithmetic.
  task automatic ref_op(input logic m, input shortint x0, input shortint y0, input shortint z0,
                        output shortint ex, output shortint ey, output shortint ez);
    shortint x, y, z, nx, ny;
    int d;
    pre_rot(m, x0, y0, z0, x, y, z);
    for (int i = 0; i < ITER; i++) begin
      if (m) d = (y < 0) ? 1 : -1;
      else   d = (z >= 0) ? 1 : -1;
      nx = shortint'(int'(x) - d * int'(y >>> i));
      ny = shortint'(int'(y) + d * int'(x >>> i));
      z  = shortint'(int'(z) - d * ang_tab[i]);
      x  = nx;
      y  = ny;
    end
    ex = x; ey = y; ez = z;
  endtask

  // Presents one operand set, follows it through RUN and checks the result at DONE.
  task automatic run_op(input logic m, input shortint x, input shortint y, input shortint z,
                        input bit chk_seq, input string tag);
    shortint px, py, pz;
    ref_op(m, x, y, z, exp_x, exp_y, exp_z);
    pre_rot(m, x, y, z, px, py, pz);
    mode_i = m; x_i = x; y_i = y; z_i = z; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_core_en"}, core_enable, 1);
    check({tag, "_core_x"}, core_x, px);
    check({tag, "_core_y"}, core_y, py);
    check({tag, "_core_z"}, core_z, pz);
    check({tag, "_core_mode_idle"}, core_mode, m);
    tick();
    in_valid = 1'b0;
    mode_i   = ~m;
    x_i      = DW'($urandom);
    for (int k = 0; k < ITER; k++) begin
      if (chk_seq) begin
        check($sformatf("%s_shift%0d", tag, k), core_shift, k);
        check($sformatf("%s_angle%0d", tag, k), core_angle, ang_tab[k]);
        check($sformatf("%s_en%0d", tag, k), core_enable, 0);
      end
      check($sformatf("%s_mode%0d", tag, k), core_mode, m);
      check($sformatf("%s_ovld%0d", tag, k), out_valid, 0);
      check($sformatf("%s_irdy%0d", tag, k), in_ready, 0);
      tick();
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_x_o"}, x_o, exp_x);
    check({tag, "_y_o"}, y_o, exp_y);
    check({tag, "_z_o"}, z_o, exp_z);
  endtask

  task automatic handshake(input int hold, input string tag);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      check($sformatf("%s_hold_vld%0d", tag, k), out_valid, 1);
      check($sformatf("%s_hold_x%0d", tag, k), x_o, exp_x);
      check($sformatf("%s_hold_irdy%0d", tag, k), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_hs_vld"}, out_valid, 0);
    check({tag, "_hs_irdy"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    shortint bx, by, bz;
    int      diff;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode_i = 1'b0; x_i = '0; y_i = '0; z_i = '0;
    for (int i = 0; i < ITER; i++)
      ang_tab[i] = $rtoi($atan(2.0 ** (-i)) * 32768.0 / PI + 0.5);

    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_x_o", x_o, 0);
    check("rst_y_o", y_o, 0);
    check("rst_z_o", z_o, 0);
    check("rst_core_en", core_enable, 0);
    check("rst_shift", core_shift, 0);
    rst_n = 1'b1;
    tick();

    // Rotation by +45 degrees of a 1/K-prescaled unit vector.
    run_op(1'b0, 16'sh26DD, 16'sh0000, 16'sh2000, 1'b1, "rot");
    diff = int'(x_o) - 11585;
    check("rot_ideal_x", (diff <= 128 && diff >= -128), 1);
    handshake(0, "rot");

    run_op(1'b1, 16'sh2000, 16'sh2000, 16'sh0000, 1'b1, "vec");
    diff = int'(z_o) - 8192;
    check("vec_ideal_z", (diff <= 128 && diff >= -128), 1);
    diff = int'(x_o) - 19079;
    check("vec_ideal_x", (diff <= 128 && diff >= -128), 1);
    handshake(2, "vec");

    // Backpressure with a competing request that must wait for the handshake.
    run_op(1'b0, 16'sh1800, -16'sh0C00, -16'sh1000, 1'b0, "bp");
    bx = 16'sh0900; by = 16'sh1100; bz = 16'sh0A00;
    mode_i = 1'b1; x_i = bx; y_i = by; z_i = bz; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_vld%0d", k), out_valid, 1);
      check($sformatf("bp_x%0d", k), x_o, exp_x);
      check($sformatf("bp_y%0d", k), y_o, exp_y);
      check($sformatf("bp_z%0d", k), z_o, exp_z);
      check($sformatf("bp_irdy%0d", k), in_ready, 0);
      check($sformatf("bp_en%0d", k), core_enable, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_vld", out_valid, 0);
    check("bp_hs_irdy", in_ready, 1);
    check("bp_hs_en", core_enable, 1);
    run_op(1'b1, bx, by, bz, 1'b0, "bp2");
    handshake(1, "bp2");

    // Asynchronous reset in the middle of RUN discards the operation.
    mode_i = 1'b0; x_i = 16'sh2000; y_i = 16'sh0400; z_i = 16'sh1000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_rst_run_irdy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_x", x_o, 0);
    check("mid_rst_y", y_o, 0);
    check("mid_rst_z", z_o, 0);
    check("mid_rst_irdy", in_ready, 1);
    check("mid_rst_shift", core_shift, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_irdy", in_ready, 1);
    run_op(1'b0, -16'sh1234, 16'sh0567, -16'sh2345, 1'b1, "post_rst");
    handshake(0, "post_rst");

`ifdef CORDIC_QUAD_PRE_EN
    run_op(1'b0, 16'sh26DD, 16'sh0000, 16'sh6000, 1'b0, "quad");
    diff = int'(x_o) + 11585;
    check("quad_ideal_x", (diff <= 128 && diff >= -128), 1);
    diff = int'(y_o) - 11585;
    check("quad_ideal_y", (diff <= 128 && diff >= -128), 1);
    handshake(0, "quad");
`endif

    for (int n = 0; n < 8; n++) begin
      shortint rx, ry, rz;
      logic    rm;
      rx = shortint'(int'($urandom_range(18000)) - 9000);
      ry = shortint'(int'($urandom_range(18000)) - 9000);
      rz = shortint'(int'($urandom_range(32000)) - 16000);
      rm = 1'($urandom_range(1));
      run_op(rm, rx, ry, rz, 1'b0, $sformatf("rnd%0d", n));
      handshake(int'($urandom_range(3)), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
